// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the memory responder: data width, lane layout and
// a helper that turns byte-lane enables into a bit mask.
package riscv_mem_responder_pkg;

    // Core data/address width shared with the rest of the riscv slice.
    localparam int XLEN      = 32;
    localparam int NUM_LANES = XLEN / 8;
    localparam int CNT_W     = 4;

    // Expand a per-byte enable vector into a per-bit mask.
    function automatic logic [XLEN-1:0] lane_mask(input logic [NUM_LANES-1:0] sel);
        logic [XLEN-1:0] mask;
        mask = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            mask[8*l +: 8] = {8{sel[l]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/riscv_mem_responder_mem_array.sv
// Word-organised storage with synchronous per-byte write and combinational read.
module riscv_mem_array
    import riscv_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic [NUM_LANES-1:0]           i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [XLEN-1:0]                i_wdata,
    output logic [XLEN-1:0]                o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    // Byte-lane write; only enabled lanes of the addressed word change.
    // NOTE: the array is deliberately left out of reset -- contents survive a
    // reset and a reset port would keep the array out of RAM primitives.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (i_be[l]) begin
                    r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/riscv_mem_responder.sv
// Single-outstanding memory responder for a riscv core: accepts one request,
// waits a fixed number of cycles, performs the access and holds the response
// until the core takes it.
module riscv_mem_responder
    import riscv_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [XLEN-1:0]      i_req_addr,
    input  logic [XLEN-1:0]      i_req_wdata,
    input  logic [NUM_LANES-1:0] i_req_byte_sel,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [XLEN-1:0]      o_rsp_rdata,
    output logic                 o_rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_t;

    localparam bit               NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [XLEN-1:0]      r_rsp_rdata;
    logic                 r_rsp_err;

    // Request fields captured at accept.
    logic                 r_we;
    logic [XLEN-1:0]      r_addr;
    logic [XLEN-1:0]      r_wdata;
    logic [NUM_LANES-1:0] r_sel;

    logic                 w_accept;
    logic                 w_in_idle;
    logic                 w_access;
    logic                 w_a_we;
    logic [XLEN-1:0]      w_a_addr;
    logic [XLEN-1:0]      w_a_wdata;
    logic [NUM_LANES-1:0] w_a_sel;
    logic                 w_oor;
    logic                 w_mem_we;
    logic [AW-1:0]        w_word_idx;
    logic [XLEN-1:0]      w_mem_rdata;
    logic [XLEN-1:0]      w_rsp_data;
    logic                 w_unused_addr_lsbs;

    assign w_accept  = i_req_valid & r_req_ready;
    assign w_in_idle = (r_state == S_IDLE);

    // The access happens either in the accept cycle (no wait states) or when
    // the wait counter expires.
    assign w_access = (w_in_idle && w_accept && NO_WAIT) ||
                      (r_state == S_WAIT && r_cnt == '0);

    // Zero-wait accesses use the live request; all others the captured copy.
    assign w_a_we    = w_in_idle ? i_req_we       : r_we;
    assign w_a_addr  = w_in_idle ? i_req_addr     : r_addr;
    assign w_a_wdata = w_in_idle ? i_req_wdata    : r_wdata;
    assign w_a_sel   = w_in_idle ? i_req_byte_sel : r_sel;

    assign w_oor      = |w_a_addr[XLEN-1:AW+2];
    assign w_word_idx = w_a_addr[AW+1:2];
    assign w_mem_we   = w_access & w_a_we & ~w_oor & ~i_rst;

    // Byte offset within a word has no meaning for a word-organised store.
    assign w_unused_addr_lsbs = ^{w_a_addr[1:0]};

    assign w_rsp_data = (w_a_we || w_oor) ? '0 : (w_mem_rdata & lane_mask(w_a_sel));

    riscv_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_be    (w_a_sel),
        .i_addr  (w_word_idx),
        .i_wdata (w_a_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Request/wait/response sequencing with registered handshake outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= i_req_we;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_sel       <= i_req_byte_sel;
                        r_req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_data;
                            r_rsp_err   <= w_oor;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_data;
                        r_rsp_err   <= w_oor;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: doc/riscv_mem_responder.md
RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; storage depth in 32-bit words, which SHALL be a power of 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; wait states inserted between request accept and response, legal range 0..15.
REQ-003 SHALL have port i_clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit; reset, synchronous and active-high.
REQ-005 SHALL have port i_req_valid, input, 1 bit; the core presents a request.
REQ-006 SHALL have port o_req_ready, output, 1 bit; the responder can accept a request.
REQ-007 SHALL have port i_req_we, input, 1 bit; 1 = store, 0 = load.
REQ-008 SHALL have port i_req_addr, input, XLEN bits; byte address.
REQ-009 SHALL have port i_req_wdata, input, XLEN bits; store data, word-aligned lanes.
REQ-010 SHALL have port i_req_byte_sel, input, 4 bits; byte-lane enables.
REQ-011 SHALL have port o_rsp_valid, output, 1 bit; a response is pending.
REQ-012 SHALL have port i_rsp_ready, input, 1 bit; the core accepts the response.
REQ-013 SHALL have port o_rsp_rdata, output, XLEN bits; load data.
REQ-014 SHALL have port o_rsp_err, output, 1 bit; out-of-range access.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 o_req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where i_req_valid & o_req_ready.
REQ-017 On accept, SHALL latch we, addr, wdata and byte_sel; later changes on the request inputs SHALL have no effect.
REQ-018 On accept with WAIT_CYCLES=0, SHALL perform the access that cycle and enter RESP; otherwise SHALL enter WAIT with a counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT, SHALL decrement the counter each cycle; at counter 0 SHALL perform the access and enter RESP.
REQ-020 Response latency: o_rsp_valid SHALL rise exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored.
REQ-022 Out of range: addr >= 4*DEPTH_WORDS SHALL give o_rsp_err=1 with no write and o_rsp_rdata=0.
REQ-023 Store SHALL write only the lanes whose byte_sel bit is 1; byte_sel=0000 SHALL be a legal no-op that still responds.
REQ-024 Load SHALL return the stored word with unselected lanes forced to 0.
REQ-025 Store response SHALL drive o_rsp_rdata=0.
REQ-026 In RESP, o_rsp_valid, o_rsp_rdata and o_rsp_err SHALL stay stable until i_rsp_ready=1; the FSM SHALL then go to IDLE on the next edge.
REQ-027 No new request SHALL be accepted in the cycle the response is consumed, giving one idle bubble minimum.
REQ-028 i_rsp_ready asserted outside RESP SHALL be ignored.
REQ-029 Outside RESP, o_rsp_valid, o_rsp_rdata and o_rsp_err SHALL be 0.

Reset
REQ-030 i_rst=1 SHALL force IDLE, counter=0, o_req_ready=1 from the first cycle after reset, and o_rsp_valid, o_rsp_rdata and o_rsp_err all 0.
REQ-031 Reset during WAIT or RESP SHALL drop the in-flight request; no write SHALL occur on or after the reset edge.
REQ-032 Storage contents SHALL NOT be reset.
REQ-033 Reset SHALL take priority over accept, access and handshake in the same cycle.

Structure
REQ-034 XLEN SHALL come from the shared riscv_configs header; FSM state encodings SHALL be localparams in this module.
REQ-035 Storage SHALL be a sub-module riscv_mem_array with synchronous per-byte write, combinational read and a DEPTH_WORDS parameter.
REQ-036 The RTL SHALL be 120-400 lines and contain no latches.

Verification
REQ-037 Reset, then store addr 0x10, wdata 0xDEADBEEF, byte_sel 1111, then load addr 0x10, byte_sel 1111 -> rdata 0xDEADBEEF, err 0, each rsp_valid exactly 3 cycles after accept (WAIT_CYCLES=2).
REQ-038 Store 0x11223344 to 0x20, then store 0xAABBCCDD with byte_sel 0101, then load with 1111 -> 0x11BB33DD; load with 0011 -> 0x000033DD.
REQ-039 Hold i_rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, o_req_ready=0; then ready=1 -> IDLE next edge, o_req_ready=1.
REQ-040 Load addr 0x1000 (DEPTH_WORDS=1024) -> err=1, rdata=0; store there -> err=1, no word in the array modified.
REQ-041 WAIT_CYCLES=0 with a back-to-back load stream and i_rsp_ready=1 -> rsp_valid 1 cycle after accept, sustained throughput of one request per 2 cycles.
REQ-042 Assert i_rst in WAIT of a store to 0x30 -> no write (0x30 keeps its old value), IDLE, rsp_valid=0, o_req_ready=1 next cycle.
